// File: rtl/wide_add_seq_if.sv
// Request/response bundle for wide_add_seq: operand handshake in, result handshake out.
interface wide_add_seq_if #(
  parameter int unsigned NSLICE = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [24*NSLICE-1:0]    a;
  logic [24*NSLICE-1:0]    b;
  logic                    cin;
  logic                    sub;
  logic                    out_valid;
  logic                    out_ready;
  logic [24*NSLICE-1:0]    sum;
  logic                    cout;
  logic                    busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/wide_add_seq.sv
// Sequential 24*NSLICE-bit adder reusing one 24-bit carry-select adder, one slice per cycle.
// Optional subtract support is built only when WAS_SUB_EN is defined.

// 24-bit carry-select adder: the upper half is precomputed for both carry values.
module C_Sel_A_24bit (
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  input  logic        cin_i,
  output logic [23:0] sum_o,
  output logic        cout_o
);
  logic [12:0] lo;
  logic [12:0] hi0;
  logic [12:0] hi1;

  assign lo  = {1'b0, a_i[11:0]} + {1'b0, b_i[11:0]} + {12'd0, cin_i};
  assign hi0 = {1'b0, a_i[23:12]} + {1'b0, b_i[23:12]};
  assign hi1 = {1'b0, a_i[23:12]} + {1'b0, b_i[23:12]} + 13'd1;

  assign sum_o  = {(lo[12] ? hi1[11:0] : hi0[11:0]), lo[11:0]};
  assign cout_o = lo[12] ? hi1[12] : hi0[12];
endmodule

module wide_add_seq #(
  parameter int unsigned NSLICE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  wide_add_seq_if.slave  bus
);
  localparam int unsigned W    = 24 * NSLICE;
  localparam int unsigned IdxW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [23:0]     add_a, add_b, add_sum;
  logic            add_cin, add_cout;
  logic            hs;
  logic            last_slice;
  logic [W-1:0]    b_eff;
  logic            cin_eff;

`ifdef WAS_SUB_EN
  // Subtraction is folded into the operands at latch time: A + ~B + ~cin.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ^ bus.cin;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_eff      = bus.b;
  assign cin_eff    = bus.cin;
`endif

  assign hs         = bus.in_valid && bus.in_ready;
  assign last_slice = (idx_q == IdxW'(NSLICE - 1));

  assign add_a   = a_q[24*int'(idx_q) +: 24];
  assign add_b   = b_q[24*int'(idx_q) +: 24];
  assign add_cin = (idx_q == '0) ? cin_q : carry_q;

  C_Sel_A_24bit u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (hs) begin
          a_d     = bus.a;
          b_d     = b_eff;
          cin_d   = cin_eff;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[24*int'(idx_q) +: 24] = add_sum;
        carry_d = add_cout;
        if (last_slice) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset window.
  assign bus.in_ready  = rst_n && (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StRun) || (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter NSLICE, default 4, SHALL set the number of 24-bit slices; operand width is 24*NSLICE (96 at default); legal range 2..8.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request holds valid operands.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  24*NSLICE  operand A.
REQ-007 b  input  24*NSLICE  operand B.
REQ-008 cin  input  1  carry-in to slice 0.
REQ-009 sub  input  1  subtract request; only meaningful when WAS_SUB_EN is defined (see REQ-030).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  24*NSLICE  result.
REQ-013 cout  output  1  carry-out of the top slice.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 The block SHALL time-share exactly one C_Sel_A_24bit instance; no second adder instance is permitted.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a handshake occurs on in_valid&&in_ready.
REQ-018 Handshake in IDLE: a, b, cin and sub are latched, the slice index is cleared to 0, and the FSM moves to RUN.
REQ-019 In RUN, each cycle: the adder is fed slice k of the latched A and B, with carry-in = latched cin for k=0 and the registered carry otherwise; 24-bit slice k of sum is written, the carry register is loaded, and k increments.
REQ-020 After slice NSLICE-1: the FSM moves to DONE, and cout is loaded from the adder carry-out.
REQ-021 out_valid SHALL be 1 only in DONE; latency from handshake to out_valid is NSLICE+1 cycles (5 at default).
REQ-022 DONE with out_ready=1: the FSM returns to IDLE in the same edge; in_ready is high the next cycle (no back-to-back overlap).
REQ-023 DONE with out_ready=0: sum, cout and out_valid SHALL hold stable indefinitely.
REQ-024 Input changes outside the handshake cycle SHALL NOT affect an operation in progress.
REQ-025 in_valid seen in RUN or DONE SHALL be ignored; the request remains pending until IDLE.
REQ-026 Overflow SHALL wrap modulo 2^(24*NSLICE), with the carry reported on cout only.
REQ-027 sum SHALL show partial slices during RUN; consumers use sum only when out_valid=1.

Reset
REQ-028 On rst_n low the block SHALL immediately enter IDLE and hold sum=0, cout=0, out_valid=0, busy=0, in_ready=0; the carry register and the slice index are cleared.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation and produce no result; in_ready=1 on the first clock edge after rst_n deasserts.

Configuration
REQ-030 Macro WAS_SUB_EN defined: when sub is latched as 1, every slice of B is inverted and the effective carry-in to slice 0 is the inverse of the latched cin, so cin=0 yields A-B. cout=1 means no borrow.
REQ-031 Macro WAS_SUB_EN undefined: the sub port exists but is ignored, no inversion logic is synthesised, and the block always adds.

Verification
REQ-032 Reset scenario: hold rst_n=0, then release -> in_ready=1 and out_valid=0 after the first edge; sum=0.
REQ-033 Add scenario: a=0x00..00FFFFFF, b=1, cin=0, out_ready=1 -> out_valid exactly 5 cycles after the handshake, sum=0x000000000000000001000000, cout=0 (exercises the carry across slice 0 to slice 1).
REQ-034 Full-ripple scenario: a=all-ones, b=0, cin=1 -> sum=0, cout=1.
REQ-035 Backpressure scenario: out_ready=0 for 10 cycles in DONE, while in_valid=1 with changing a -> sum, cout and out_valid stable, and no new handshake until out_ready=1.
REQ-036 Reset mid-op scenario: assert rst_n=0 at slice 2 -> out_valid never rises for that operation; a new request completes correctly.
REQ-037 Subtract scenario (WAS_SUB_EN only): a=5, b=7, sub=1, cin=0 -> sum=all-ones minus 1 (i.e. -2 mod 2^96), cout=0; a=7, b=5 -> sum=2, cout=1.
